// File: rtl/traka_pkg.sv
// Shared definitions for the bottle-line belt controller: FSM state
// encoding, input indices and default timing constants.
package traka_pkg;

  // Controller states
  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_RUN     = 3'd1,
    ST_STOP    = 3'd2,
    ST_HOLD    = 3'd3,
    ST_ADVANCE = 3'd4,
    ST_FAULT   = 3'd5
  } state_e;

  // Default timing, in clk cycles
  localparam int unsigned DEB_CYC_DEF     = 500_000;
  localparam int unsigned HOLD_CYC_DEF    = 50_000_000;
  localparam int unsigned POMAK_CYC_DEF   = 300_000_000;
  localparam int unsigned TIMEOUT_CYC_DEF = 1_000_000_000;

  // Widths
  localparam int TIMER_W = 32;
  localparam int CNT_W   = 8;

  // Positions of the raw inputs in the filter bank
  localparam int IN_START = 0;
  localparam int IN_STOP  = 1;
  localparam int IN_IR    = 2;
  localparam int IN_PUMP  = 3;
  localparam int N_IN     = 4;

endpackage

// File: rtl/traka_kontrola_debounce.sv
// Input conditioning for one asynchronous line: two-flop synchroniser
// followed by a stability filter. The filtered output only follows the
// synchronised input after it has differed from the current output for
// DEB_CYC consecutive cycles. All line inputs idle high, so reset puts
// every stage at 1.
module debounce
  import traka_pkg::*;
#(
  parameter int unsigned DEB_CYC = DEB_CYC_DEF
) (
  input  logic clk,
  input  logic rst,
  input  logic din,
  output logic dout
);

  localparam int CW = (DEB_CYC > 1) ? $clog2(DEB_CYC) : 1;
  localparam logic [CW-1:0] LAST = CW'(DEB_CYC - 1);

  logic [1:0]    sync_q, sync_d;
  logic          dout_q, dout_d;
  logic [CW-1:0] cnt_q, cnt_d;

  // Synchroniser shift and stability filter next-state
  always_comb begin
    sync_d = {sync_q[0], din};
    dout_d = dout_q;
    cnt_d  = '0;
    if (sync_q[1] != dout_q) begin
      if (cnt_q == LAST) begin
        dout_d = sync_q[1];
      end else begin
        cnt_d = cnt_q + 1'b1;
      end
    end
  end

  // Filter registers, reset to the idle (high) level
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q <= 2'b11;
      dout_q <= 1'b1;
      cnt_q  <= '0;
    end else begin
      sync_q <= sync_d;
      dout_q <= dout_d;
      cnt_q  <= cnt_d;
    end
  end

  assign dout = dout_q;

endmodule

// File: rtl/traka_kontrola.sv
// Conveyor-belt controller for a bottle filling station.
// A bottle stops the belt under the pump, the belt waits for the pump to
// run and finish, holds briefly, then advances the filled bottle away.
// Optional feature macro: TRAKA_BROJAC_EN builds the filled-bottle counter
// on broj_flasa; without it broj_flasa is constant 0 and the FSM is
// unchanged.
module traka_kontrola
  import traka_pkg::*;
#(
  parameter int unsigned DEB_CYC     = DEB_CYC_DEF,
  parameter int unsigned HOLD_CYC    = HOLD_CYC_DEF,
  parameter int unsigned POMAK_CYC   = POMAK_CYC_DEF,
  parameter int unsigned TIMEOUT_CYC = TIMEOUT_CYC_DEF
) (
  input  logic       clk,
  input  logic       rst,
  input  logic       start_taster,
  input  logic       stop_taster,
  input  logic       ir_pumpa,
  input  logic       pumpa_switch,
  output logic       traka_switch,
  output logic       dioda_traka,
  output logic       greska,
  output logic [7:0] broj_flasa
);

  logic [N_IN-1:0] raw_in;
  logic [N_IN-1:0] filt;

  assign raw_in[IN_START] = start_taster;
  assign raw_in[IN_STOP]  = stop_taster;
  assign raw_in[IN_IR]    = ir_pumpa;
  assign raw_in[IN_PUMP]  = pumpa_switch;

  genvar gi;
  generate
    for (gi = 0; gi < N_IN; gi++) begin : g_deb
      debounce #(
        .DEB_CYC(DEB_CYC)
      ) u_deb (
        .clk (clk),
        .rst (rst),
        .din (raw_in[gi]),
        .dout(filt[gi])
      );
    end
  endgenerate

  // Buttons and sensors are active-low; give them positive meanings
  logic start_press, stop_press, bottle_present, pump_f;
  assign start_press    = ~filt[IN_START];
  assign stop_press     = ~filt[IN_STOP];
  assign bottle_present = ~filt[IN_IR];
  assign pump_f         = filt[IN_PUMP];

  state_e              state_q, state_d;
  logic [TIMER_W-1:0]  timer_q, timer_d;
  logic                pump_prev_q, pump_prev_d;
  logic                pump_seen_q, pump_seen_d;
  logic                traka_q, traka_d;
  logic                greska_q, greska_d;

  // Pump finished = filtered relay drive going from on (0) back to off (1)
  logic pump_rise, expired;
  assign pump_rise = pump_f & ~pump_prev_q;
  // Timer holds the number of cycles left in the current timed state,
  // so a state loaded with N lasts exactly N cycles
  assign expired   = (timer_q <= TIMER_W'(1));

  // State, timer and pump-edge registers
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      timer_q     <= '0;
      pump_prev_q <= 1'b1;
      pump_seen_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      timer_q     <= timer_d;
      pump_prev_q <= pump_prev_d;
      pump_seen_q <= pump_seen_d;
    end
  end

  // Next-state and shared timer control; stop overrides everything
  always_comb begin
    state_d     = state_q;
    timer_d     = timer_q;
    pump_prev_d = pump_f;
    pump_seen_d = pump_seen_q;
    case (state_q)
      ST_IDLE: begin
        if (start_press) state_d = ST_RUN;
      end
      ST_RUN: begin
        if (bottle_present) begin
          state_d     = ST_STOP;
          timer_d     = TIMER_W'(TIMEOUT_CYC);
          pump_seen_d = 1'b0;
        end
      end
      ST_STOP: begin
        if (!pump_f) pump_seen_d = 1'b1;
        if (pump_rise) begin
          state_d = ST_HOLD;
          timer_d = TIMER_W'(HOLD_CYC);
        end else if (expired) begin
          // Pump already running: keep waiting for it to finish
          if (!pump_seen_q && pump_f) state_d = ST_FAULT;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_HOLD: begin
        if (expired) begin
          state_d = ST_ADVANCE;
          timer_d = TIMER_W'(POMAK_CYC);
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_ADVANCE: begin
        if (!bottle_present) begin
          state_d = ST_RUN;
          timer_d = '0;
        end else if (expired) begin
          state_d = ST_FAULT;
          timer_d = '0;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      ST_FAULT: begin
        state_d = ST_FAULT;
      end
      default: begin
        state_d = ST_IDLE;
        timer_d = '0;
      end
    endcase
    if (stop_press) begin
      state_d = ST_IDLE;
      timer_d = '0;
    end
  end

  // Output decode from the current state (registered below, so outputs
  // trail the state by one cycle); motor relay is inverse logic
  always_comb begin
    traka_d  = ~((state_q == ST_RUN) || (state_q == ST_ADVANCE));
    greska_d = (state_q == ST_FAULT);
  end

  // Output registers
  always_ff @(posedge clk) begin
    if (rst) begin
      traka_q  <= 1'b1;
      greska_q <= 1'b0;
    end else begin
      traka_q  <= traka_d;
      greska_q <= greska_d;
    end
  end

  assign traka_switch = traka_q;
  assign dioda_traka  = traka_q;
  assign greska       = greska_q;

`ifdef TRAKA_BROJAC_EN
  logic [CNT_W-1:0] broj_q, broj_d;

  // Count a bottle when its hold ends and it starts advancing; saturate
  always_comb begin
    broj_d = broj_q;
    if ((state_q == ST_HOLD) && (state_d == ST_ADVANCE) && (broj_q != '1)) begin
      broj_d = broj_q + 1'b1;
    end
  end

  // Bottle counter register, kept through stop and fault
  always_ff @(posedge clk) begin
    if (rst) broj_q <= '0;
    else     broj_q <= broj_d;
  end

  assign broj_flasa = broj_q;
`else
  assign broj_flasa = '0;
`endif

endmodule

// File: tb/tb_traka_kontrola.sv
// Self-checking bench for traka_kontrola with short timing parameters.
// Expected values come from a transaction-level model: latencies are sums
// of the filter, FSM and output delays plus the timed-state lengths, and
// the bottle count is a saturating tally of completed fills (0 when the
// TRAKA_BROJAC_EN counter is not built).
module tb_traka_kontrola;

  localparam int DEB   = 4;
  localparam int HOLD  = 10;
  localparam int POMAK = 20;
  localparam int TOUT  = 50;
  // raw input change -> visible output change:
  // 2 sync + DEB filter + 1 state + 1 output register
  localparam int LAT   = DEB + 4;

  logic       clk = 1'b0;
  logic       rst = 1'b1;
  logic       start_taster = 1'b1;
  logic       stop_taster  = 1'b1;
  logic       ir_pumpa     = 1'b1;
  logic       pumpa_switch = 1'b1;
  logic       traka_switch, dioda_traka, greska;
  logic [7:0] broj_flasa;

  int n_tests = 0;
  int n_fail  = 0;
  int bottles = 0;

  always #5 clk = ~clk;

  traka_kontrola #(
    .DEB_CYC    (DEB),
    .HOLD_CYC   (HOLD),
    .POMAK_CYC  (POMAK),
    .TIMEOUT_CYC(TOUT)
  ) dut (
    .clk         (clk),
    .rst         (rst),
    .start_taster(start_taster),
    .stop_taster (stop_taster),
    .ir_pumpa    (ir_pumpa),
    .pumpa_switch(pumpa_switch),
    .traka_switch(traka_switch),
    .dioda_traka (dioda_traka),
    .greska      (greska),
    .broj_flasa  (broj_flasa)
  );

  task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("[TB] FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic int exp_broj();
`ifdef TRAKA_BROJAC_EN
    return (bottles > 255) ? 255 : bottles;
`else
    return 0;
`endif
  endfunction

  task automatic tick(input int k);
    repeat (k) @(negedge clk);
  endtask

  // Cycles until the chosen output (0 = traka_switch, 1 = greska) reaches
  // val; -1 if it never does within maxc
  task automatic wait_out(input int which, input logic val, input int maxc, output int n);
    n = -1;
    for (int i = 1; i <= maxc; i++) begin
      @(negedge clk);
      if (((which == 0) ? traka_switch : greska) === val) begin
        n = i;
        break;
      end
    end
  endtask

  task automatic press_start();
    int n;
    start_taster = 1'b0;
    wait_out(0, 1'b0, LAT + 10, n);
    chk("start_run_lat", n, LAT);
    chk("start_dioda", dioda_traka, 1'b0);
    start_taster = 1'b1;
    $display("[TB] start press: motor on after %0d cycles", n);
  endtask

  task automatic press_stop(input int which, input logic val, input string tag);
    int n;
    stop_taster = 1'b0;
    wait_out(which, val, LAT + 10, n);
    chk(tag, n, LAT);
    chk({tag, "_motor"}, traka_switch, 1'b1);
    chk({tag, "_broj"}, broj_flasa, exp_broj());
    stop_taster = 1'b1;
    tick(LAT + 2);
    $display("[TB] stop press (%s): reacted after %0d cycles", tag, n);
  endtask

  task automatic arrive();
    int n;
    ir_pumpa = 1'b0;
    wait_out(0, 1'b1, LAT + 10, n);
    chk("arrive_stop_lat", n, LAT);
    chk("arrive_dioda", dioda_traka, 1'b1);
  endtask

  task automatic fill(input bit jam);
    int n;
    pumpa_switch = 1'b0;
    tick(DEB + int'($urandom_range(0, 4)));
    pumpa_switch = 1'b1;
    wait_out(0, 1'b0, LAT + HOLD + 20, n);
    bottles++;
    chk("hold_len", n, LAT + HOLD);
    chk("adv_dioda", dioda_traka, 1'b0);
    chk("adv_broj", broj_flasa, exp_broj());
    if (jam) begin
      wait_out(1, 1'b1, POMAK + 20, n);
      chk("jam_fault_lat", n, POMAK);
      chk("jam_motor", traka_switch, 1'b1);
      chk("jam_broj", broj_flasa, exp_broj());
      $display("[TB] bottle %0d jammed: fault after %0d cycles", bottles, n);
    end else begin
      ir_pumpa = 1'b1;
      tick(POMAK + int'($urandom_range(2, 6)));
      chk("clear_motor", traka_switch, 1'b0);
      chk("clear_greska", greska, 1'b0);
      $display("[TB] bottle %0d filled, broj_flasa=%0d", bottles, broj_flasa);
    end
  endtask

  initial begin
    int n;
    int g;
    // Reset state
    tick(3);
    chk("rst_motor", traka_switch, 1'b1);
    chk("rst_dioda", dioda_traka, 1'b1);
    chk("rst_greska", greska, 1'b0);
    chk("rst_broj", broj_flasa, 8'd0);
    rst = 1'b0;
    tick(LAT + 2);
    chk("idle_motor", traka_switch, 1'b1);
    $display("[TB] reset released: idle");

    // Start and stop together in IDLE: stop wins
    start_taster = 1'b0;
    stop_taster  = 1'b0;
    tick(LAT + 10);
    chk("both_motor", traka_switch, 1'b1);
    chk("both_greska", greska, 1'b0);
    start_taster = 1'b1;
    stop_taster  = 1'b1;
    tick(LAT + 2);
    chk("both_after", traka_switch, 1'b1);
    $display("[TB] start+stop together: stayed idle");

    // Normal bottle cycle
    press_start();
    arrive();
    fill(1'b0);

    // Short sensor glitch in RUN is rejected
    g = int'($urandom_range(1, DEB - 1));
    ir_pumpa = 1'b0;
    tick(g);
    ir_pumpa = 1'b1;
    tick(LAT + 10);
    chk("glitch_motor", traka_switch, 1'b0);
    $display("[TB] %0d-cycle ir glitch: belt kept running", g);

    // Pulse of exactly DEB cycles is accepted; pump never runs -> timeout
    ir_pumpa = 1'b0;
    tick(DEB);
    ir_pumpa = 1'b1;
    wait_out(0, 1'b1, LAT + 10, n);
    chk("pulse_stop_lat", n, LAT - DEB);
    wait_out(1, 1'b1, TOUT + 20, n);
    chk("pulse_timeout", n, TOUT);
    $display("[TB] %0d-cycle ir pulse: stop, then fault after %0d cycles", DEB, n);
    press_stop(1, 1'b0, "stop_clears_fault");

    // Pump never starts with bottle held
    press_start();
    arrive();
    wait_out(1, 1'b1, TOUT + 20, n);
    chk("nopump_timeout", n, TOUT);
    chk("nopump_motor", traka_switch, 1'b1);
    chk("nopump_broj", broj_flasa, exp_broj());
    $display("[TB] pump never on: fault after %0d cycles", n);
    press_stop(1, 1'b0, "stop_clears_fault2");
    ir_pumpa = 1'b1;
    tick(LAT + 2);

    // Jammed bottle during ADVANCE
    press_start();
    arrive();
    fill(1'b1);
    press_stop(1, 1'b0, "stop_after_jam");
    ir_pumpa = 1'b1;
    tick(LAT + 2);

    // Stop while running
    press_start();
    press_stop(0, 1'b1, "stop_in_run");

    // Reset pulse during ADVANCE
    press_start();
    arrive();
    pumpa_switch = 1'b0;
    tick(DEB + 2);
    pumpa_switch = 1'b1;
    wait_out(0, 1'b0, LAT + HOLD + 20, n);
    bottles++;
    chk("pre_rst_adv", n, LAT + HOLD);
    rst      = 1'b1;
    ir_pumpa = 1'b1;
    @(negedge clk);
    bottles = 0;
    chk("midrst_motor", traka_switch, 1'b1);
    chk("midrst_dioda", dioda_traka, 1'b1);
    chk("midrst_greska", greska, 1'b0);
    chk("midrst_broj", broj_flasa, 8'd0);
    rst = 1'b0;
    tick(LAT + 2);
    chk("midrst_idle", traka_switch, 1'b1);
    $display("[TB] reset during advance: idle, count cleared");

    // 256 bottles: counter saturates
    press_start();
    for (int i = 0; i < 256; i++) begin
      arrive();
      fill(1'b0);
    end
    chk("sat_broj", broj_flasa, exp_broj());
    $display("[TB] after %0d bottles broj_flasa=%0d", bottles, broj_flasa);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

  // Guard against a stuck run
  initial begin
    #2_000_000;
    $display("[TB] FAIL watchdog: got timeout expected completion");
    $fatal(1, "watchdog");
  end

endmodule
